// File: rtl/b11_rx_feeder.sv
// b11_rx_feeder: serial frame receiver feeding a small word FIFO, drained by a
// strobe generator that presents one word at a time to a downstream b11 with
// an active-low strobe and a minimum spacing of GAP cycles between strobes.
module b11_rx_feeder #(
  parameter int GAP   = 12,
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic       rx_tick,
  output logic [5:0] x_out,
  output logic       stbi,
  output logic       frm_err,
  output logic       ovf,
  output logic [3:0] fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] GAP_END = 7'(GAP - 2);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {S_IDLE, S_STRB, S_GAP} st_state_t;

  rx_state_t rx_state, rx_state_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [5:0] shift, shift_next;
  logic       push;
  logic       bad_stop;

  st_state_t  st_state, st_state_next;
  logic [5:0] gap_cnt, gap_cnt_next;
  logic       pop;

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full;
  logic          wr_en;

  // Receive FSM next state: advances only on bit ticks. Data bits are
  // shifted in at the top so that after six ticks the first bit sits at
  // position 0 (LSB first).
  always_comb begin
    rx_state_next = rx_state;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    push          = 1'b0;
    bad_stop      = 1'b0;
    if (rx_tick) begin
      case (rx_state)
        R_IDLE: begin
          if (!rx_bit) begin
            rx_state_next = R_DATA;
            bit_cnt_next  = 3'd0;
          end
        end
        R_DATA: begin
          shift_next   = {rx_bit, shift[5:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd5) rx_state_next = R_STOP;
        end
        R_STOP: begin
          // A low stop bit is reported and swallowed; it is never a start bit.
          if (rx_bit) push = 1'b1;
          else        bad_stop = 1'b1;
          rx_state_next = R_IDLE;
        end
        default: rx_state_next = R_IDLE;
      endcase
    end
  end

  // Receive FSM registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state <= R_IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 6'd0;
      frm_err  <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
      frm_err  <= bad_stop;
    end
  end

  // Strobe FSM next state: pop on leaving S_IDLE, one strobe cycle, then
  // S_GAP long enough that strobes are GAP cycles apart when back to back.
  always_comb begin
    st_state_next = st_state;
    gap_cnt_next  = gap_cnt;
    pop           = 1'b0;
    case (st_state)
      S_IDLE: begin
        if (fifo_cnt != 4'd0) begin
          st_state_next = S_STRB;
          pop           = 1'b1;
        end
      end
      S_STRB: begin
        st_state_next = S_GAP;
        gap_cnt_next  = 6'd0;
      end
      S_GAP: begin
        gap_cnt_next = gap_cnt + 6'd1;
        if ({1'b0, gap_cnt} + 7'd1 >= GAP_END) st_state_next = S_IDLE;
      end
      default: st_state_next = S_IDLE;
    endcase
  end

  // A full FIFO still takes a word when a pop frees the slot that same cycle.
  assign full  = (fifo_cnt == FULL_CNT);
  assign wr_en = push && (!full || pop);
  assign stbi  = (st_state != S_STRB);

  // Strobe FSM, FIFO bookkeeping, overflow flag and output word register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_state <= S_IDLE;
      gap_cnt  <= 6'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= 4'd0;
      ovf      <= 1'b0;
      x_out    <= 6'd0;
    end else begin
      st_state <= st_state_next;
      gap_cnt  <= gap_cnt_next;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        x_out  <= mem[rd_ptr];
      end
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 4'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 4'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  // Word storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

endmodule

// File: tb/tb_b11_rx_feeder.sv
// Bench for b11_rx_feeder: instance 0 uses GAP=12, instance 1 uses GAP=63.
// Expected strobes are queued as frames are sent; monitors compare on stbi=0.
module tb_b11_rx_feeder;

  typedef struct {
    logic [5:0] w;
    int         at;   // exact strobe cycle, or -1
    int         gap;  // exact spacing from previous strobe, or 0
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_bit_v  [2];
  logic       rx_tick_v [2];
  logic [5:0] x_out_v   [2];
  logic       stbi_v    [2];
  logic       frm_err_v [2];
  logic       ovf_v     [2];
  logic [3:0] fifo_cnt_v[2];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_stb [2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  b11_rx_feeder #(.GAP(12), .DEPTH(4)) dut_a (
    .clock(clock), .reset(reset), .rx_bit(rx_bit_v[0]), .rx_tick(rx_tick_v[0]),
    .x_out(x_out_v[0]), .stbi(stbi_v[0]), .frm_err(frm_err_v[0]),
    .ovf(ovf_v[0]), .fifo_cnt(fifo_cnt_v[0])
  );

  b11_rx_feeder #(.GAP(63), .DEPTH(4)) dut_b (
    .clock(clock), .reset(reset), .rx_bit(rx_bit_v[1]), .rx_tick(rx_tick_v[1]),
    .x_out(x_out_v[1]), .stbi(stbi_v[1]), .frm_err(frm_err_v[1]),
    .ovf(ovf_v[1]), .fifo_cnt(fifo_cnt_v[1])
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int qsize(int sel);
    if (sel == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic void push_exp(int sel, logic [5:0] w, int at, int gap);
    exp_t e;
    e.w = w; e.at = at; e.gap = gap;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endfunction

  // Monitor action for one observed strobe cycle.
  task automatic strobe_seen(int sel);
    exp_t e;
    if (qsize(sel) == 0) begin
      checks++;
      errors++;
      $display("FAIL strobe%0d: unexpected strobe x_out=%b at cycle %0d, expected none",
               sel, x_out_v[sel], cyc);
    end else begin
      if (sel == 0) e = q0.pop_front();
      else          e = q1.pop_front();
      $display("strobe dut%0d word %b cycle %0d", sel, x_out_v[sel], cyc);
      chk($sformatf("x_out%0d", sel), int'(x_out_v[sel]), int'(e.w));
      if (e.at >= 0) chk($sformatf("latency%0d", sel), cyc, e.at);
      if (e.gap > 0) chk($sformatf("spacing%0d", sel), cyc - last_stb[sel], e.gap);
    end
    last_stb[sel] = cyc;
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    always @(negedge clock) begin
      if (!reset && !stbi_v[gi]) strobe_seen(gi);
    end
  end

  // Drives bits[0..n-1] on consecutive ticks; entered and left at posedge+1.
  task automatic send_bits(int sel, logic [15:0] bits, int n);
    for (int i = 0; i < n; i++) begin
      rx_bit_v[sel]  = bits[i];
      rx_tick_v[sel] = 1'b1;
      @(posedge clock);
      #1;
    end
    rx_tick_v[sel] = 1'b0;
    rx_bit_v[sel]  = 1'b1;
  endtask

  // Sends start, six data bits LSB first, stop; c is the stop-edge cycle.
  task automatic send_frame(int sel, logic [5:0] d, logic stop, output int c);
    send_bits(sel, {8'h00, stop, d, 1'b0}, 8);
    c = cyc;
  endtask

  task automatic wait_drain(int sel, int budget);
    int n = 0;
    while (qsize(sel) != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("drain%0d", sel), qsize(sel), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int c;
    for (int i = 0; i < 2; i++) begin
      rx_bit_v[i]  = 1'b1;
      rx_tick_v[i] = 1'b0;
      last_stb[i]  = 0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_x_out%0d", i), int'(x_out_v[i]), 0);
      chk($sformatf("rst_stbi%0d", i), int'(stbi_v[i]), 1);
      chk($sformatf("rst_frm_err%0d", i), int'(frm_err_v[i]), 0);
      chk($sformatf("rst_ovf%0d", i), int'(ovf_v[i]), 0);
      chk($sformatf("rst_fifo_cnt%0d", i), int'(fifo_cnt_v[i]), 0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // Line sequence 0,1,0,1,1,0,0,1: data bits 1,0,1,1,0,0 LSB first = 001101.
    send_frame(0, 6'b001101, 1'b1, c);
    push_exp(0, 6'b001101, c + 1, 0);
    @(negedge clock);
    chk("single_fifo_cnt_after_push", int'(fifo_cnt_v[0]), 1);
    wait_drain(0, 30);
    chk("single_fifo_cnt_end", int'(fifo_cnt_v[0]), 0);
    repeat (20) @(posedge clock);
    #1;
    send_frame(0, 6'b011010, 1'b1, c);
    push_exp(0, 6'b011010, c + 1, 0);
    wait_drain(0, 30);

    // Bad stop bit: one-cycle error pulse, nothing queued, no false start.
    repeat (20) @(posedge clock);
    #1;
    send_frame(0, 6'b111111, 1'b0, c);
    @(negedge clock);
    chk("frm_err_pulse", int'(frm_err_v[0]), 1);
    chk("frm_err_fifo_cnt", int'(fifo_cnt_v[0]), 0);
    @(negedge clock);
    chk("frm_err_clear", int'(frm_err_v[0]), 0);
    @(posedge clock);
    #1;
    send_bits(0, 16'hFFFF, 12);
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("frm_err_no_word", int'(fifo_cnt_v[0]), 0);
    @(posedge clock);
    #1;

    // Five back-to-back frames, GAP=12: strobes exactly 12 cycles apart.
    repeat (20) @(posedge clock);
    #1;
    for (int k = 1; k <= 5; k++) begin
      send_frame(0, 6'(k), 1'b1, c);
      push_exp(0, 6'(k), (k == 1) ? c + 1 : -1, (k == 1) ? 0 : 12);
    end
    wait_drain(0, 100);
    chk("burst_ovf", int'(ovf_v[0]), 0);
    chk("burst_fifo_cnt", int'(fifo_cnt_v[0]), 0);

    // Six frames, GAP=63: word 1 strobed, 2-5 queued, 6 dropped.
    for (int k = 1; k <= 6; k++) begin
      send_frame(1, 6'h10 + 6'(k), 1'b1, c);
      if (k <= 5) push_exp(1, 6'h10 + 6'(k), (k == 1) ? c + 1 : -1, (k == 1) ? 0 : 63);
    end
    @(negedge clock);
    chk("ovf_fifo_cnt_full", int'(fifo_cnt_v[1]), 4);
    chk("ovf_set", int'(ovf_v[1]), 1);
    wait_drain(1, 400);
    chk("ovf_fifo_cnt_end", int'(fifo_cnt_v[1]), 0);
    chk("ovf_sticky", int'(ovf_v[1]), 1);

    // Push into a full FIFO on the exact cycle of the strobe-FSM pop.
    pulse_reset();
    for (int k = 1; k <= 5; k++) begin
      send_frame(1, 6'h30 + 6'(k), 1'b1, c);
      push_exp(1, 6'h30 + 6'(k), (k == 1) ? c + 1 : -1, (k == 1) ? 0 : 63);
    end
    @(negedge clock);
    chk("popfull_cnt_before", int'(fifo_cnt_v[1]), 4);
    chk("popfull_ovf_before", int'(ovf_v[1]), 0);
    repeat (24) @(posedge clock);
    #1;
    send_frame(1, 6'h36, 1'b1, c);
    push_exp(1, 6'h36, -1, 63);
    @(negedge clock);
    chk("popfull_cnt_after", int'(fifo_cnt_v[1]), 4);
    chk("popfull_ovf_after", int'(ovf_v[1]), 0);
    wait_drain(1, 450);

    // Asynchronous reset mid-frame and mid-gap with two words queued.
    pulse_reset();
    send_frame(1, 6'h2A, 1'b1, c);
    push_exp(1, 6'h2A, c + 1, 0);
    send_frame(1, 6'h15, 1'b1, c);
    send_frame(1, 6'h33, 1'b1, c);
    @(negedge clock);
    chk("arst_queued", int'(fifo_cnt_v[1]), 2);
    chk("arst_drained_first", qsize(1), 0);
    @(posedge clock);
    #1;
    send_bits(1, 16'b0100, 4);
    #2 reset = 1'b1;
    #1;
    chk("arst_x_out", int'(x_out_v[1]), 0);
    chk("arst_stbi", int'(stbi_v[1]), 1);
    chk("arst_fifo_cnt", int'(fifo_cnt_v[1]), 0);
    chk("arst_frm_err", int'(frm_err_v[1]), 0);
    chk("arst_ovf", int'(ovf_v[1]), 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    send_bits(1, 16'hFFFF, 4);
    repeat (80) @(posedge clock);
    #1;
    chk("arst_no_word", int'(fifo_cnt_v[1]), 0);
    send_frame(1, 6'h0C, 1'b1, c);
    push_exp(1, 6'h0C, c + 1, 0);
    wait_drain(1, 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
